// File: rtl/matrix_key_scanner_pkg.sv
// Shared definitions for the keypad scanner and the display/IO blocks that
// consume its key codes.
//   scan_state_e     : scanner FSM states (SCAN, PRESS_DB, HELD)
//   KEY_CODE_W       : width of a key index (row*4+col)
//   lowest_low_col() : index of the lowest active-low column in a sample
package matrix_key_scanner_pkg;

  localparam int KEY_CODE_W = 4;
  localparam int KP_ROWS    = 4;
  localparam int KP_COLS    = 4;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2
  } scan_state_e;

  // Priority encode: when several keys in one row are down, the lowest
  // column wins. The caller has already checked that at least one bit is low.
  function automatic logic [1:0] lowest_low_col(input logic [KP_COLS-1:0] cols_n);
    logic [1:0] idx;
    if (!cols_n[0])      idx = 2'd0;
    else if (!cols_n[1]) idx = 2'd1;
    else if (!cols_n[2]) idx = 2'd2;
    else                 idx = 2'd3;
    return idx;
  endfunction

endpackage

// File: rtl/matrix_key_scanner_scan_tick_gen.sv
// Scan-tick prescaler.
//   clk   : system clock
//   reset : asynchronous, active-high
//   tick  : high for one clk cycle out of every TICK_DIV, the first one
//           TICK_DIV cycles after reset release
module scan_tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    tick  = (cnt_q == CNT_W'(TICK_DIV - 1));
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/matrix_key_scanner.sv
// 4x4 matrix keypad scanner with press/release debounce and a one-deep
// valid/ready output holding register.
//   clk          : system clock
//   reset        : asynchronous, active-high
//   row_n[3:0]   : row drive, active-low, exactly one row low
//   col_n[3:0]   : column sense, active-low, asynchronous to clk
//   key_code[3:0]: accepted key index, row*4+col
//   key_valid    : key_code holds a key not yet consumed
//   key_ready    : consumer takes key_code when key_valid & key_ready
//   key_overflow : sticky, a debounced key was dropped while one was pending
module matrix_key_scanner
  import matrix_key_scanner_pkg::*;
#(
  parameter int TICK_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [KP_ROWS-1:0]    row_n,
  input  logic [KP_COLS-1:0]    col_n,
  output logic [KEY_CODE_W-1:0] key_code,
  output logic                  key_valid,
  input  logic                  key_ready,
  output logic                  key_overflow
);

  localparam int DB_W = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_TICKS - 1);

  logic tick;

  scan_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  logic [KP_COLS-1:0]    col_meta_q, col_meta_d;
  logic [KP_COLS-1:0]    col_s_q, col_s_d;
  scan_state_e           state_q, state_d;
  logic [1:0]            row_q, row_d;
  logic [KP_ROWS-1:0]    row_n_q, row_n_d;
  logic [1:0]            col_q, col_d;
  logic [DB_W-1:0]       db_cnt_q, db_cnt_d;
  logic [KEY_CODE_W-1:0] key_code_q, key_code_d;
  logic                  key_valid_q, key_valid_d;
  logic                  key_overflow_q, key_overflow_d;

  logic emit;
  logic handshake;

  // State register, synchronizer and output holding registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_meta_q     <= '1;
      col_s_q        <= '1;
      state_q        <= SCAN;
      row_q          <= 2'd0;
      row_n_q        <= 4'b1110;
      col_q          <= 2'd0;
      db_cnt_q       <= '0;
      key_code_q     <= '0;
      key_valid_q    <= 1'b0;
      key_overflow_q <= 1'b0;
    end else begin
      col_meta_q     <= col_meta_d;
      col_s_q        <= col_s_d;
      state_q        <= state_d;
      row_q          <= row_d;
      row_n_q        <= row_n_d;
      col_q          <= col_d;
      db_cnt_q       <= db_cnt_d;
      key_code_q     <= key_code_d;
      key_valid_q    <= key_valid_d;
      key_overflow_q <= key_overflow_d;
    end
  end

  // Next-state logic. Everything moves only on a scan tick; the row index
  // and its one-cold drive pattern advance together.
  always_comb begin
    col_meta_d = col_n;
    col_s_d    = col_meta_q;
    state_d    = state_q;
    row_d      = row_q;
    row_n_d    = row_n_q;
    col_d      = col_q;
    db_cnt_d   = db_cnt_q;
    if (tick) begin
      case (state_q)
        SCAN: begin
          if (col_s_q != 4'hF) begin
            col_d    = lowest_low_col(col_s_q);
            db_cnt_d = '0;
            state_d  = PRESS_DB;
          end else begin
            row_d   = row_q + 2'd1;
            row_n_d = {row_n_q[2:0], row_n_q[3]};
          end
        end
        PRESS_DB: begin
          if (!col_s_q[col_q]) begin
            if (db_cnt_q == DB_LAST) begin
              db_cnt_d = '0;
              state_d  = HELD;
            end else begin
              db_cnt_d = db_cnt_q + DB_W'(1);
            end
          end else begin
            // Bounce: give up on this key and keep scanning.
            state_d = SCAN;
            row_d   = row_q + 2'd1;
            row_n_d = {row_n_q[2:0], row_n_q[3]};
          end
        end
        HELD: begin
          // Any key in the driven row restarts the release count, so a
          // second key pressed in the same row holds us here too.
          if (col_s_q == 4'hF) begin
            if (db_cnt_q == DB_LAST) begin
              db_cnt_d = '0;
              state_d  = SCAN;
              row_d    = row_q + 2'd1;
              row_n_d  = {row_n_q[2:0], row_n_q[3]};
            end else begin
              db_cnt_d = db_cnt_q + DB_W'(1);
            end
          end else begin
            db_cnt_d = '0;
          end
        end
        default: begin
          state_d  = SCAN;
          db_cnt_d = '0;
        end
      endcase
    end
  end

  // Output logic. A key emitted in the same cycle the consumer takes the
  // pending one replaces it instead of being dropped.
  always_comb begin
    emit = tick && (state_q == PRESS_DB) && !col_s_q[col_q] && (db_cnt_q == DB_LAST);
    handshake      = key_valid_q & key_ready;
    key_code_d     = key_code_q;
    key_valid_d    = key_valid_q;
    key_overflow_d = key_overflow_q;
    if (handshake) begin
      key_valid_d    = 1'b0;
      key_overflow_d = 1'b0;
    end
    if (emit) begin
      if (!key_valid_q || key_ready) begin
        key_code_d  = KEY_CODE_W'({row_q, col_q});
        key_valid_d = 1'b1;
      end else begin
        key_overflow_d = 1'b1;
      end
    end
  end

  assign row_n        = row_n_q;
  assign key_code     = key_code_q;
  assign key_valid    = key_valid_q;
  assign key_overflow = key_overflow_q;

endmodule

// File: doc/matrix_key_scanner.md
MATRIX_KEY_SCANNER -- requirements
Module: matrix_key_scanner

Interface
REQ-001 Parameter TICK_DIV, default 50000, meaning clk cycles per scan tick (1 ms at 50 MHz); legal range 2 or more.
REQ-002 Parameter DEBOUNCE_TICKS, default 10, meaning consecutive stable ticks required to accept a press or a release; legal range 1 or more.
REQ-003 clk  input  1  system clock; all state updates on posedge clk.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 row_n  output  4  keypad row drive; active-low, exactly one bit low at all times.
REQ-006 col_n  input  4  keypad column sense; active-low, asynchronous to clk, externally pulled high.
REQ-007 key_code  output  4  accepted key index, row*4+col.
REQ-008 key_valid  output  1  key_code holds an unconsumed key.
REQ-009 key_ready  input  1  consumer accepts key_code on a cycle where key_valid and key_ready are both 1.
REQ-010 key_overflow  output  1  sticky flag: a debounced key was dropped because key_valid was still pending.

Function
REQ-011 col_n SHALL pass through a 2-flop synchronizer; all column logic SHALL use only the synchronized value (col_s).
REQ-012 A one-cycle tick SHALL assert every TICK_DIV clk cycles, counting from reset release.
REQ-013 In state SCAN, on each tick the block SHALL sample col_s for the currently driven row; if no column is low, it SHALL advance the driven row (0->1->2->3->0, row r drives row_n bit r low).
REQ-014 In SCAN, if the tick sample shows any col_s bit low, the block SHALL latch the row and the lowest-index low column, keep the row driven, clear the stable counter, and go to PRESS_DB.
REQ-015 In PRESS_DB, on each tick: if the latched column is still low, increment the counter, else return to SCAN and advance the row; when the counter reaches DEBOUNCE_TICKS, go to HELD and emit the key.
REQ-016 Emit rule: if key_valid=0, or key_valid=1 and key_ready=1 in the same cycle, load key_code and set key_valid=1; otherwise drop the key and set key_overflow=1.
REQ-017 In HELD, the row stays driven; on each tick, all col_s high SHALL increment the release counter and any low SHALL clear it; at DEBOUNCE_TICKS the block SHALL go to SCAN and advance the row.
REQ-018 A handshake (key_valid&key_ready) SHALL clear key_valid and key_overflow on the next edge, unless REQ-016 reloads in that cycle; a reload SHALL keep key_valid=1 and update key_code.
REQ-019 key_ready SHALL be ignored while key_valid=0; key_code SHALL stay stable while key_valid=1 and not accepted.
REQ-020 Multiple keys in one row: only the lowest column SHALL be reported; keys in other rows SHALL be ignored until return to SCAN.
REQ-021 Latency: a key held stable is reported at most (4+DEBOUNCE_TICKS)*TICK_DIV+3 clk cycles after col_n falls.

Reset
REQ-022 While reset=1: row_n=4'b1110, key_code=0, key_valid=0, key_overflow=0, state SCAN, tick and debounce counters 0, synchronizer flops 1.
REQ-023 Reset asserted mid-debounce or mid-HELD SHALL abandon the key without emitting it; after release, scanning SHALL restart at row 0.

Structure
REQ-024 State encoding (SCAN, PRESS_DB, HELD) and the code width constant (4) SHALL live in the shared package/header for the display/IO blocks.
REQ-025 The tick prescaler SHALL be a separate sub-module, scan_tick_gen (parameter TICK_DIV, outputs a 1-cycle tick).
REQ-026 All outputs SHALL be registered.

Verification (TICK_DIV=4, DEBOUNCE_TICKS=3)
REQ-027 Reset, no keys -> row_n cycles 1110,1101,1011,0111,1110 advancing every 4 clk; key_valid stays 0.
REQ-028 Press row 2/col 1 stable, key_ready=1 -> one key_valid pulse with key_code=9; no second emit until release is debounced.
REQ-029 Press row 1/col 3 for 2 ticks then release (bounce) -> no key_valid; scanning resumes at row 2.
REQ-030 key_ready=0; press and release key 5, then key 6 -> key_code holds 5, key_overflow=1; then key_ready=1 for one cycle -> key_valid=0 and key_overflow=0.
REQ-031 Row 0 with cols 2 and 0 low together -> key_code=0.
REQ-032 Reset asserted during PRESS_DB of key 15 -> no emit, row_n=1110 immediately, all outputs at reset values.
